// File: rtl/trit_pkg.sv
// Shared trit encodings, base-3 weights and buffer state type for the trit packer.
package trit_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_0       = 2'b00;
    localparam trit_t TRIT_1       = 2'b01;
    localparam trit_t TRIT_2       = 2'b10;
    localparam trit_t TRIT_ILLEGAL = 2'b11;

    localparam int TRITS_PER_BYTE = 5;

    localparam logic [7:0] POW3 [TRITS_PER_BYTE] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/trit_lane_acc.sv
// One lane's base-3 byte accumulator; o_acc_next is the value including this cycle's trit,
// so the parent can shift a completed byte in the same cycle the accumulator clears.
module trit_lane_acc
    import trit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  trit_t       i_trit,
    input  logic [2:0]  i_tcnt,
    input  logic        i_add,
    input  logic        i_clear,
    output logic [7:0]  o_acc_next
);

    logic [7:0] r_acc;
    logic [7:0] w_term;

    // An illegal 11 trit contributes nothing, exactly like a 0.
    always_comb begin
        w_term = '0;
        if (i_add) begin
            case (i_trit)
                TRIT_1:  w_term = POW3[i_tcnt];
                TRIT_2:  w_term = {POW3[i_tcnt][6:0], 1'b0};
                TRIT_0, TRIT_ILLEGAL: w_term = '0;
                default: w_term = '0;
            endcase
        end
    end

    assign o_acc_next = r_acc + w_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/trit_pack_buffer.sv
// Packs LANES trits/beat into bytes and hash-sized blocks; in_ready drops while a block is flushed or held.
// Optional sticky illegal-trit flag `err` when TRIT_PACK_ERR_EN is defined.
module trit_pack_buffer
    import trit_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int HASH_BITS = 1088
) (
    input  logic                                clk,
    input  logic                                ovr_rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [2*LANES-1:0]                  in_trits,
    input  logic                                flush,
    output logic                                blk_valid,
    input  logic                                blk_ready,
    output logic [HASH_BITS-1:0]                blk_data,
    output logic [$clog2(HASH_BITS/8+1)-1:0]    blk_len,
    output logic                                blk_last,
    output logic                                busy
`ifdef TRIT_PACK_ERR_EN
    ,
    output logic                                err
`endif
);

    localparam int SLOT_BITS = 8 * LANES;
    localparam int SLOTS     = HASH_BITS / SLOT_BITS;
    localparam int SW        = $clog2(SLOTS + 1);
    localparam int LEN_W     = $clog2(HASH_BITS / 8 + 1);

    if ((HASH_BITS % SLOT_BITS) != 0) begin : g_bad_cfg
        $error("trit_pack_buffer: HASH_BITS must be a multiple of 8*LANES");
    end

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_blk_valid;
    logic [LEN_W-1:0]       r_blk_len;
    logic                   r_blk_last;
    logic                   r_busy;
    logic [2:0]             r_tcnt;
    logic [SW-1:0]          r_scnt;
    logic [HASH_BITS-1:0]   r_buf;

    logic                   w_beat;
    logic                   w_tcnt_last;
    logic                   w_grp_done;
    logic [2:0]             w_tcnt_eff;
    logic [SW-1:0]          w_scnt_grp;
    logic                   w_flush_eff;
    logic                   w_close;
    logic                   w_shift_fill;
    logic [SW-1:0]          w_scnt_new;
    logic [LEN_W-1:0]       w_len_new;
    logic [SLOT_BITS-1:0]   w_slot;

    // r_in_ready is only ever set in FILL, so it doubles as the state qualifier for beats.
    assign w_beat       = in_valid && r_in_ready;
    assign w_tcnt_last  = (r_tcnt == 3'(TRITS_PER_BYTE - 1));
    assign w_grp_done   = w_beat && w_tcnt_last;
    assign w_tcnt_eff   = w_beat ? (w_tcnt_last ? 3'd0 : r_tcnt + 3'd1) : r_tcnt;
    assign w_scnt_grp   = r_scnt + SW'(w_grp_done);
    assign w_flush_eff  = flush && (r_state == FILL) && ((w_tcnt_eff != 3'd0) || (w_scnt_grp != '0));
    assign w_close      = w_flush_eff && (w_tcnt_eff != 3'd0);
    assign w_shift_fill = w_grp_done || w_close;
    assign w_scnt_new   = r_scnt + SW'(w_shift_fill);
    assign w_len_new    = LEN_W'(w_scnt_new) * LEN_W'(LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        trit_lane_acc u_acc (
            .clk        (clk),
            .rst        (ovr_rst),
            .i_trit     (in_trits[2*k +: 2]),
            .i_tcnt     (r_tcnt),
            .i_add      (w_beat),
            .i_clear    (w_shift_fill),
            .o_acc_next (w_slot[8*k +: 8])
        );
    end

    always_ff @(posedge clk or posedge ovr_rst) begin
        if (ovr_rst) begin
            r_state     <= FILL;
            r_in_ready  <= 1'b1;
            r_blk_valid <= 1'b0;
            r_blk_len   <= '0;
            r_blk_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_tcnt      <= '0;
            r_scnt      <= '0;
            r_buf       <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    r_tcnt <= w_close ? 3'd0 : w_tcnt_eff;
                    if (w_shift_fill) begin
                        r_buf  <= {w_slot, r_buf[HASH_BITS-1:SLOT_BITS]};
                        r_scnt <= w_scnt_new;
                    end
                    if (w_shift_fill && (w_scnt_new == SW'(SLOTS))) begin
                        r_state     <= HOLD;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_blk_valid <= 1'b1;
                        r_blk_len   <= w_len_new;
                        r_blk_last  <= w_flush_eff;
                    end else if (w_flush_eff) begin
                        r_state    <= FLUSH;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_blk_len  <= w_len_new;
                        r_blk_last <= 1'b1;
                    end
                end
                // Zero slots push the packed bytes down until the first byte sits at [7:0].
                FLUSH: begin
                    r_buf  <= {{SLOT_BITS{1'b0}}, r_buf[HASH_BITS-1:SLOT_BITS]};
                    r_scnt <= r_scnt + SW'(1);
                    if ((r_scnt + SW'(1)) == SW'(SLOTS)) begin
                        r_state     <= HOLD;
                        r_blk_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (blk_ready) begin
                        r_state     <= FILL;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_blk_valid <= 1'b0;
                        r_blk_len   <= '0;
                        r_blk_last  <= 1'b0;
                        r_scnt      <= '0;
                        r_buf       <= '0;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign blk_valid = r_blk_valid;
    assign blk_data  = r_buf;
    assign blk_len   = r_blk_len;
    assign blk_last  = r_blk_last;
    assign busy      = r_busy;

`ifdef TRIT_PACK_ERR_EN
    logic r_err;
    logic w_any_ill;

    always_comb begin
        w_any_ill = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (in_trits[2*k +: 2] == TRIT_ILLEGAL) begin
                w_any_ill = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge ovr_rst) begin
        if (ovr_rst) begin
            r_err <= 1'b0;
        end else if (w_beat && w_any_ill) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_trit_pack_buffer.sv
// Directed bench for trit_pack_buffer with LANES=2, HASH_BITS=1088.
module tb_trit_pack_buffer;

    logic          clk = 1'b0;
    logic          ovr_rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_trits;
    logic          flush;
    logic          blk_valid;
    logic          blk_ready;
    logic [1087:0] blk_data;
    logic [7:0]    blk_len;
    logic          blk_last;
    logic          busy;
`ifdef TRIT_PACK_ERR_EN
    logic          err;
`endif

    int total = 0;
    int bad   = 0;
    int n;
    logic [1087:0] exp_blk;
    logic [1:0] l0v [5];
    logic [1:0] l1v [5];

    always #5 clk = ~clk;

    trit_pack_buffer #(.LANES(2), .HASH_BITS(1088)) dut (
        .clk       (clk),
        .ovr_rst   (ovr_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_trits  (in_trits),
        .flush     (flush),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_len   (blk_len),
        .blk_last  (blk_last),
        .busy      (busy)
`ifdef TRIT_PACK_ERR_EN
        ,
        .err       (err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [1087:0] exp);
        total++;
        assert (blk_data === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, blk_data, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] l0, input logic [1:0] l1);
        in_valid = 1'b1;
        in_trits = {l1, l0};
        tick();
        in_valid = 1'b0;
        in_trits = 4'b0000;
    endtask

    task automatic wait_blk(output int cnt);
        cnt = 0;
        while (blk_valid !== 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    task automatic handshake();
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        ovr_rst   = 1'b1;
        in_valid  = 1'b0;
        in_trits  = 4'b0000;
        flush     = 1'b0;
        blk_ready = 1'b0;
        tick();
        tick();
        ovr_rst = 1'b0;
        tick();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_len", blk_len, 0);
        chk("rst_blk_last", blk_last, 0);
        chk("rst_busy", busy, 0);
        chk_blk("rst_blk_data", '0);
`ifdef TRIT_PACK_ERR_EN
        chk("rst_err", err, 0);
`endif

        // Partial group then asynchronous reset mid-FILL.
        beat(2'd2, 2'd2);
        beat(2'd2, 2'd1);
        beat(2'd1, 2'd2);
        ovr_rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_blk_valid", blk_valid, 0);
        @(posedge clk);
        #1;
        ovr_rst = 1'b0;
        tick();

        // Full block: group 0 and group 67 carry data, the rest are zero.
        l0v = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
        l1v = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2};
        for (int g = 0; g < 68; g++) begin
            if (g == 67) begin
                l0v = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
                l1v = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
            end
            for (int t = 0; t < 5; t++) begin
                if (g == 67 && t == 4) chk("pre_full_blk_valid", blk_valid, 0);
                if (g == 0 || g == 67) beat(l0v[t], l1v[t]);
                else beat(2'd0, 2'd0);
            end
        end
        exp_blk = '0;
        exp_blk[7:0]       = 8'd242;
        exp_blk[15:8]      = 8'd163;
        exp_blk[1079:1072] = 8'd121;
        exp_blk[1087:1080] = 8'd21;
        chk("full_blk_valid", blk_valid, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_busy", busy, 1);
        chk("full_byte0", blk_data[7:0], 242);
        chk("full_byte1", blk_data[15:8], 163);
        chk("full_blk_len", blk_len, 136);
        chk("full_blk_last", blk_last, 0);
        chk_blk("full_blk_data", exp_blk);

        // Backpressure: offered beats must be ignored while held.
        in_valid = 1'b1;
        in_trits = 4'b1010;
        repeat (10) tick();
        chk("bp_in_ready", in_ready, 0);
        chk("bp_blk_valid", blk_valid, 1);
        chk("bp_blk_len", blk_len, 136);
        chk_blk("bp_blk_data", exp_blk);
        in_valid = 1'b0;
        in_trits = 4'b0000;
        handshake();
        chk("hs_blk_valid", blk_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hs_busy", busy, 0);
        chk_blk("hs_blk_data", '0);

        // Flush of a partial second group.
        repeat (7) beat(2'd1, 2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy", busy, 1);
        chk("fl_in_ready", in_ready, 0);
        chk("fl_blk_valid_early", blk_valid, 0);
        wait_blk(n);
        chk("fl_cycles", n, 66);
        exp_blk = '0;
        exp_blk[31:0] = 32'h0404_7979;
        chk_blk("fl_blk_data", exp_blk);
        chk("fl_blk_len", blk_len, 4);
        chk("fl_blk_last", blk_last, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("hold_flush_valid", blk_valid, 1);
        chk("hold_flush_len", blk_len, 4);
        handshake();
        chk("fl_hs_blk_valid", blk_valid, 0);

        // Flush with nothing buffered is a no-op.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_busy", busy, 0);
        chk("empty_in_ready", in_ready, 1);
        repeat (3) tick();
        chk("empty_blk_valid", blk_valid, 0);

        // Flush on the 5th beat: the completed group is the only slot.
        beat(2'd0, 2'd2);
        repeat (3) beat(2'd0, 2'd0);
        in_valid = 1'b1;
        in_trits = {2'd0, 2'd1};
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        in_trits = 4'b0000;
        flush    = 1'b0;
        wait_blk(n);
        chk("edge_cycles", n, 67);
        exp_blk = '0;
        exp_blk[15:0] = 16'h0251;
        chk_blk("edge_blk_data", exp_blk);
        chk("edge_blk_len", blk_len, 2);
        chk("edge_blk_last", blk_last, 1);
        handshake();

`ifdef TRIT_PACK_ERR_EN
        beat(2'd1, 2'd3);
        repeat (4) beat(2'd0, 2'd0);
        chk("err_set", err, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_blk(n);
        exp_blk = '0;
        exp_blk[15:0] = 16'h0001;
        chk_blk("err_blk_data", exp_blk);
        handshake();
        chk("err_sticky", err, 1);
        ovr_rst = 1'b1;
        #1;
        chk("err_cleared", err, 0);
        @(posedge clk);
        #1;
        ovr_rst = 1'b0;
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
